tlul_sram_adapter: RTL

TL-UL device-side adapter that terminates one crossbar device port and drives a single-port synchronous SRAM with fixed one-cycle read latency. It sits directly downstream of a crossbar device socket, such as the ICCM or DCCM port, and converts A-channel Get/PutFull/PutPartial requests into SRAM strobes. It returns AccessAck/AccessAckData on the D channel through a small response queue, with request legality checking.

---
 rtl/tlul_sram_adapter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tlul_sram_adapter.sv
// rtl/tlul_sram_adapter.sv - TL-UL device port to one-cycle-latency single-port SRAM adapter
// Optional full request legality checking is enabled by defining TLUL_SRAM_ADAPTER_ERRCHK_EN.

package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;
endpackage

module tlul_sram_adapter
    import tlul_pkg::*;
#(
    parameter int SramAw      = 12,
    parameter int Outstanding = 2,
    parameter bit ErrOnWrite  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              req_o,
    output logic              we_o,
    output logic [SramAw-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       wmask_o,
    input  logic [31:0]       rdata_i
);
    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

    logic [2:0]      cnt;
    logic [PtrW-1:0] wptr, rptr, rd_idx;
    logic            rd_pend;

    logic [2:0]  q_opcode  [Outstanding];
    logic [1:0]  q_size    [Outstanding];
    logic [7:0]  q_source  [Outstanding];
    logic        q_error   [Outstanding];
    logic        q_is_read [Outstanding];
    logic [31:0] q_data    [Outstanding];

    logic a_ready, accept, d_valid, d_hs, is_get, is_put, err, issue;
    logic [31:0] head_data;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Outstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign a_ready = (cnt < 3'(Outstanding));
    assign accept  = tl_i.a_valid && a_ready;
    assign d_valid = (cnt != 3'd0);
    assign d_hs    = d_valid && tl_i.d_ready;
    assign is_get  = (tl_i.a_opcode == OpGet);
    assign is_put  = (tl_i.a_opcode == OpPutFull) || (tl_i.a_opcode == OpPutPartial);

`ifdef TLUL_SRAM_ADAPTER_ERRCHK_EN
    logic [3:0] byte_mask;
    always_comb begin
        byte_mask = 4'h0;
        case (tl_i.a_size)
            2'd0:    byte_mask = 4'b0001 << tl_i.a_address[1:0];
            2'd1:    byte_mask = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
            2'd2:    byte_mask = 4'b1111;
            default: byte_mask = 4'h0;
        endcase
        err = ErrOnWrite && is_put;
        if (!(is_get || is_put))                                     err = 1'b1;
        if (tl_i.a_size > 2'd2)                                      err = 1'b1;
        if (tl_i.a_size == 2'd1 && tl_i.a_address[0])                err = 1'b1;
        if (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'd0)      err = 1'b1;
        if ((tl_i.a_mask & ~byte_mask) != 4'h0)                      err = 1'b1;
        if (tl_i.a_opcode == OpPutFull && tl_i.a_mask != byte_mask)  err = 1'b1;
    end
`else
    assign err = ErrOnWrite && is_put;
`endif

    // SRAM strobes are gated so the address/data buses idle at zero between accesses
    assign issue   = accept && !err;
    assign req_o   = issue;
    assign we_o    = issue && !is_get;
    assign addr_o  = issue ? tl_i.a_address[SramAw+1:2] : '0;
    assign wdata_o = issue ? tl_i.a_data : '0;
    assign wmask_o = issue ? {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                              {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}} : '0;

    logic unused;
    assign unused = ^{tl_i.a_param, tl_i.a_address[31:SramAw+2], tl_i.a_address[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= 3'd0;
            wptr    <= '0;
            rptr    <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            case ({accept, d_hs})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            if (accept) wptr <= next_ptr(wptr);
            if (d_hs)   rptr <= next_ptr(rptr);
            rd_pend <= issue && is_get;
            rd_idx  <= wptr;
        end
    end

    // rd_pend is cleared by reset, so a discarded in-flight read never lands
    always_ff @(posedge clk_i) begin
        if (accept) begin
            q_opcode[wptr]  <= is_get ? OpAccessAckData : OpAccessAck;
            q_size[wptr]    <= tl_i.a_size;
            q_source[wptr]  <= tl_i.a_source;
            q_error[wptr]   <= err;
            q_is_read[wptr] <= issue && is_get;
        end
        if (rd_pend) q_data[rd_idx] <= rdata_i;
    end

    assign head_data = (rd_pend && rd_idx == rptr) ? rdata_i : q_data[rptr];

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = q_opcode[rptr];
            tl_o.d_size   = q_size[rptr];
            tl_o.d_source = q_source[rptr];
            tl_o.d_error  = q_error[rptr];
            tl_o.d_data   = q_is_read[rptr] ? head_data : 32'h0;
        end
    end
endmodule
